// File: rtl/yield_sum_caller_pkg.sv
// -----------------------------------------------------------------------------
// yield_sum_caller_pkg
// Shared types and constants for the yield_sum_caller block.
//   YSC_WIDTH    : default data width of arguments, yields, sum and count
//   ysc_state_e  : caller FSM states (IDLE, CALL, COLLECT, EMIT)
// -----------------------------------------------------------------------------
package yield_sum_caller_pkg;

    localparam int unsigned YSC_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALL    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_EMIT    = 2'd3
    } ysc_state_e;

endpackage : yield_sum_caller_pkg

// File: rtl/yield_sum_caller.sv
// -----------------------------------------------------------------------------
// yield_sum_caller
// Caller side of the generator start/ready/valid/done protocol. Launches one
// external callee generator with registered arguments, sums every yielded c_0
// and counts the yields, then presents (sum, count) downstream through the
// same generator protocol so the block can itself be nested as a callee.
//
// Ports:
//   _clock, _reset            : clock, asynchronous active-high reset
//   _start, base/limit/step   : run request and callee arguments (sampled in IDLE)
//   _ready                    : downstream accepts result
//   _done, _valid, _0, _1     : idle flag, result valid, sum, yield count
//   c_start, c_ready          : start pulse / ready towards callee
//   c_base, c_limit, c_step   : registered callee arguments
//   c_done, c_valid, c_0, c_1 : callee status and yield (c_1 unused)
//
// Build option:
//   YIELD_SUM_CALLER_THROTTLE_EN : when defined, c_ready toggles every cycle
//   in COLLECT (starting low), accepting yields only on alternate edges.
// -----------------------------------------------------------------------------
module yield_sum_caller
    import yield_sum_caller_pkg::*;
#(
    parameter int unsigned WIDTH = YSC_WIDTH
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic                    _ready,
    input  logic signed [WIDTH-1:0] base,
    input  logic signed [WIDTH-1:0] limit,
    input  logic signed [WIDTH-1:0] step,
    output logic                    _done,
    output logic                    _valid,
    output logic signed [WIDTH-1:0] _0,
    output logic signed [WIDTH-1:0] _1,
    output logic                    c_start,
    output logic                    c_ready,
    output logic signed [WIDTH-1:0] c_base,
    output logic signed [WIDTH-1:0] c_limit,
    output logic signed [WIDTH-1:0] c_step,
    input  logic                    c_done,
    input  logic                    c_valid,
    input  logic signed [WIDTH-1:0] c_0,
    input  logic signed [WIDTH-1:0] c_1
);

    localparam logic signed [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

`ifdef YIELD_SUM_CALLER_THROTTLE_EN
    localparam logic THROTTLE = 1'b1;
`else
    localparam logic THROTTLE = 1'b0;
`endif

    ysc_state_e              state_q, state_d;
    logic signed [WIDTH-1:0] sum_q, sum_d;
    logic signed [WIDTH-1:0] cnt_q, cnt_d;
    logic signed [WIDTH-1:0] out0_q, out0_d;
    logic signed [WIDTH-1:0] out1_q, out1_d;
    logic signed [WIDTH-1:0] base_q, base_d;
    logic signed [WIDTH-1:0] limit_q, limit_d;
    logic signed [WIDTH-1:0] step_q, step_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;
    logic                    cstart_q, cstart_d;
    logic                    cready_q, cready_d;

    // Handshakes with the callee only count on edges where we drive c_ready.
    logic take_yield_s;
    logic take_done_s;

    // c_1 is part of the callee interface but does not enter the reduction.
    logic unused_c1_s;

    assign take_yield_s = cready_q & c_valid;
    assign take_done_s  = cready_q & c_done;
    assign unused_c1_s  = ^c_1;

    // Next-state and next-output logic for the caller FSM.
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        out0_d   = out0_q;
        out1_d   = out1_q;
        base_d   = base_q;
        limit_d  = limit_q;
        step_d   = step_q;
        done_d   = done_q;
        valid_d  = valid_q;
        cstart_d = 1'b0;
        cready_d = cready_q;

        case (state_q)
            ST_IDLE: begin
                if (_start) begin
                    base_d   = base;
                    limit_d  = limit;
                    step_d   = step;
                    sum_d    = ZERO;
                    cnt_d    = ZERO;
                    cstart_d = 1'b1;
                    cready_d = 1'b1;
                    done_d   = 1'b0;
                    valid_d  = 1'b0;
                    state_d  = ST_CALL;
                end else begin
                    cready_d = 1'b0;
                end
            end

            // The callee still shows done from its previous run during this
            // cycle, so neither c_done nor c_valid is looked at here.
            ST_CALL: begin
                cready_d = ~THROTTLE;
                state_d  = ST_COLLECT;
            end

            ST_COLLECT: begin
                if (take_yield_s) begin
                    sum_d = sum_q + c_0;
                    cnt_d = cnt_q + ONE;
                end else begin
                    sum_d = sum_q;
                end
                // A yield arriving together with done is folded in first.
                if (take_done_s) begin
                    out0_d   = sum_d;
                    out1_d   = cnt_d;
                    valid_d  = 1'b1;
                    cready_d = 1'b0;
                    state_d  = ST_EMIT;
                end else if (THROTTLE) begin
                    cready_d = ~cready_q;
                end else begin
                    cready_d = 1'b1;
                end
            end

            ST_EMIT: begin
                if (_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                done_d   = 1'b1;
                valid_d  = 1'b0;
                cready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset to the idle values.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q  <= ST_IDLE;
            sum_q    <= ZERO;
            cnt_q    <= ZERO;
            out0_q   <= ZERO;
            out1_q   <= ZERO;
            base_q   <= ZERO;
            limit_q  <= ZERO;
            step_q   <= ZERO;
            done_q   <= 1'b1;
            valid_q  <= 1'b0;
            cstart_q <= 1'b0;
            cready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            base_q   <= base_d;
            limit_q  <= limit_d;
            step_q   <= step_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            cstart_q <= cstart_d;
            cready_q <= cready_d;
        end
    end

    assign _done   = done_q;
    assign _valid  = valid_q;
    assign _0      = out0_q;
    assign _1      = out1_q;
    assign c_start = cstart_q;
    assign c_ready = cready_q;
    assign c_base  = base_q;
    assign c_limit = limit_q;
    assign c_step  = step_q;

endmodule : yield_sum_caller

// File: doc/yield_sum_caller.md
Name: yield_sum_caller

Overview:
- Caller side of the generator start/ready/valid/done protocol.
- Launches one callee generator (e.g. hrange) with registered arguments and drives the callee's _ready.
- Consumes every yielded tuple and reduces the run to one result: sum of callee _0 and yield count.
- Presents that result downstream through the same generator protocol, so it nests as a callee of a higher-level caller.

Parameters:
WIDTH, 32, data width of arguments, callee outputs, sum and count (signed, two's complement)

Ports:
_clock  input  1  single clock, all state on rising edge
_reset  input  1  asynchronous, active-high reset
_start  input  1  one-cycle request; base/limit/step sampled when high and block idle
_ready  input  1  downstream accepts result
base  input  WIDTH  callee argument
limit  input  WIDTH  callee argument
step  input  WIDTH  callee argument
_done  output  1  high when idle and no result pending
_valid  output  1  result on _0/_1 is valid
_0  output  WIDTH  sum of all callee _0 yields (wraps mod 2^WIDTH)
_1  output  WIDTH  number of callee yields (wraps mod 2^WIDTH)
c_start  output  1  start pulse to callee
c_ready  output  1  ready to callee
c_base  output  WIDTH  registered argument to callee
c_limit  output  WIDTH  registered argument to callee
c_step  output  WIDTH  registered argument to callee
c_done  input  1  callee done
c_valid  input  1  callee yield valid
c_0  input  WIDTH  callee yield field 0
c_1  input  WIDTH  callee yield field 1 (ignored by reduction)

Behaviour:
- Reset values:
  - state=IDLE, _done=1, _valid=0.
  - _0, _1, sum and count = 0.
  - c_start=0, c_ready=0, c_base/c_limit/c_step=0.
- IDLE:
  - _start=1 at edge N registers the arguments and clears sum/count → CALL.
  - _start while not IDLE is ignored.
- CALL (exactly one cycle, N+1): c_start=1, c_ready=1, _done=0 → COLLECT.
- COLLECT:
  - c_ready=1; _done=0, _valid=0.
  - On each edge with c_ready && c_valid: sum += c_0, count += 1.
  - On an edge with c_ready && c_done: go to EMIT. A yield with c_valid and c_done in the same cycle is counted before leaving.
  - The c_done sampled in the CALL-cycle edge is ignored, because the callee still shows stale done from its previous run.
- EMIT:
  - c_ready=0; _valid=1, _done=0.
  - _0=sum and _1=count, held stable while _ready=0.
  - On the edge with _ready=1 → IDLE: _valid=0, _done=1. _0/_1 keep their last values.
- Minimum latency from _start to _valid: 3 cycles + callee run length.
- Callee with zero yields (base>=limit): result _0=0, _1=0.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). The callee shares _reset.
- Arithmetic: plain WIDTH-bit signed add; overflow wraps, no saturation.

Optional Feature:
YIELD_SUM_CALLER_THROTTLE_EN:
- Defined: in COLLECT, c_ready toggles every cycle, starting at 0 in the first COLLECT cycle. Yields and done are accepted only on edges where c_ready=1, so the callee must hold its outputs. The result is identical to the unthrottled build; latency is roughly doubled.
- Undefined: c_ready is constantly 1 in CALL/COLLECT.

Decomposition:
- Package yield_sum_caller_pkg: state enum (IDLE, CALL, COLLECT, EMIT) and WIDTH default constant.
- No sub-module. The callee is instantiated externally. The bench and top-level tests wire it to hrange.

Test Plan:
- hrange(0,10,2), _ready=1 → single _valid pulse with _0=20, _1=5; _done returns to 1 the following cycle.
- hrange(5,5,1), empty range → _0=0, _1=0, _valid one cycle.
- hrange(0,10,2) with _ready held 0 for 4 cycles during EMIT → _valid, _0=20, _1=5 stable throughout; IDLE only after _ready=1.
- _start re-pulsed during COLLECT → ignored; result still 20/5. A back-to-back second run immediately after IDLE also returns 20/5 (sum/count cleared).
- _reset asserted mid-COLLECT (after 2 yields) → asynchronously _done=1, _valid=0, c_ready=0. A fresh run of hrange(0,10,2) then gives 20/5.
- THROTTLE_EN build with hrange(-6,6,3) → c_ready alternates, no yield lost or double-counted; _0=-6, _1=4.
